// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the ram_arbiter block.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_M = 1'b1;

  localparam logic RAM_READ  = 1'b1;
  localparam logic RAM_WRITE = 1'b0;

endpackage

// File: rtl/ram_arbiter_select.sv
// Combinational winner selection between the fetch and load/store ports.
// Round-robin arbitration is enabled by defining RAM_ARBITER_ROUND_ROBIN_EN.
module ram_arbiter_select
  import ram_arbiter_pkg::*;
(
  input  logic f_req,
  input  logic m_req,
  input  logic rr_ptr,
  output logic grant,
  output logic winner
);

  assign grant = f_req | m_req;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  // rr_ptr names the port preferred when both request.
  always_comb begin
    winner = PORT_F;
    if (f_req && m_req) begin
      winner = rr_ptr;
    end else if (m_req) begin
      winner = PORT_M;
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = rr_ptr;
  assign winner     = m_req ? PORT_M : PORT_F;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port RAM between fetch (F) and load/store (M) ports,
// one access per IDLE -> ACCESS -> ACK sequence.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  FReq,
  input  logic [ADDR_WIDTH-1:0] FAddr,
  output logic                  FAck,
  output logic [DATA_WIDTH-1:0] FRData,
  input  logic                  MReq,
  input  logic                  MWrite,
  input  logic [ADDR_WIDTH-1:0] MAddr,
  input  logic [DATA_WIDTH-1:0] MWData,
  output logic                  MAck,
  output logic [DATA_WIDTH-1:0] MRData,
  output logic                  RamEnable,
  output logic                  RamReadWrite,
  output logic [ADDR_WIDTH-1:0] RamAddress,
  output logic [DATA_WIDTH-1:0] RamDataIn,
  input  logic [DATA_WIDTH-1:0] RamDataOut,
  output logic                  Busy
);

  state_t                state_q, state_d;
  logic                  win_q, win_d;
  logic                  rr_q, rr_d;
  logic                  ram_en_q, ram_en_d;
  logic                  ram_rw_q, ram_rw_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic                  f_ack_q, f_ack_d;
  logic                  m_ack_q, m_ack_d;
  logic [DATA_WIDTH-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_WIDTH-1:0] m_rdata_q, m_rdata_d;

  logic grant;
  logic winner;

  ram_arbiter_select u_select (
    .f_req  (FReq),
    .m_req  (MReq),
    .rr_ptr (rr_q),
    .grant  (grant),
    .winner (winner)
  );

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    rr_d       = rr_q;
    ram_en_d   = 1'b0;
    ram_rw_d   = ram_rw_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    f_ack_d    = 1'b0;
    m_ack_d    = 1'b0;
    f_rdata_d  = f_rdata_q;
    m_rdata_d  = m_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d  = ACCESS;
          win_d    = winner;
          rr_d     = ~winner;
          ram_en_d = 1'b1;
          if (winner == PORT_M) begin
            ram_addr_d = MAddr;
            ram_din_d  = MWData;
            ram_rw_d   = MWrite ? RAM_WRITE : RAM_READ;
          end else begin
            ram_addr_d = FAddr;
            ram_rw_d   = RAM_READ;
          end
        end
      end
      ACCESS: begin
        state_d = ACK;
        if (win_q == PORT_M) begin
          m_ack_d = 1'b1;
          if (ram_rw_q == RAM_READ) begin
            m_rdata_d = RamDataOut;
          end
        end else begin
          f_ack_d   = 1'b1;
          f_rdata_d = RamDataOut;
        end
      end
      ACK: begin
        // Requests are deliberately ignored here so a late-dropped Req is harmless.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      win_q      <= PORT_F;
      rr_q       <= PORT_F;
      ram_en_q   <= 1'b0;
      ram_rw_q   <= RAM_READ;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      f_ack_q    <= 1'b0;
      m_ack_q    <= 1'b0;
      f_rdata_q  <= '0;
      m_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      rr_q       <= rr_d;
      ram_en_q   <= ram_en_d;
      ram_rw_q   <= ram_rw_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      f_ack_q    <= f_ack_d;
      m_ack_q    <= m_ack_d;
      f_rdata_q  <= f_rdata_d;
      m_rdata_q  <= m_rdata_d;
    end
  end

  assign RamEnable    = ram_en_q;
  assign RamReadWrite = ram_rw_q;
  assign RamAddress   = ram_addr_q;
  assign RamDataIn    = ram_din_q;
  assign FAck         = f_ack_q;
  assign MAck         = m_ack_q;
  assign FRData       = f_rdata_q;
  assign MRData       = m_rdata_q;
  assign Busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural RAM model.
module tb_ram_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        FReq;
  logic [15:0] FAddr;
  logic        FAck;
  logic [31:0] FRData;
  logic        MReq;
  logic        MWrite;
  logic [15:0] MAddr;
  logic [31:0] MWData;
  logic        MAck;
  logic [31:0] MRData;
  logic        RamEnable;
  logic        RamReadWrite;
  logic [15:0] RamAddress;
  logic [31:0] RamDataIn;
  logic [31:0] RamDataOut;
  logic        Busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  int          en_count = 0;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  localparam logic [15:0] FirstAddr = 16'h0020;
`else
  localparam logic [15:0] FirstAddr = 16'h0021;
`endif

  ram_arbiter dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .FReq         (FReq),
    .FAddr        (FAddr),
    .FAck         (FAck),
    .FRData       (FRData),
    .MReq         (MReq),
    .MWrite       (MWrite),
    .MAddr        (MAddr),
    .MWData       (MWData),
    .MAck         (MAck),
    .MRData       (MRData),
    .RamEnable    (RamEnable),
    .RamReadWrite (RamReadWrite),
    .RamAddress   (RamAddress),
    .RamDataIn    (RamDataIn),
    .RamDataOut   (RamDataOut),
    .Busy         (Busy)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (RamEnable && !RamReadWrite) begin
      mem[RamAddress] <= RamDataIn;
    end
    if (RamEnable) en_count <= en_count + 1;
  end

  assign RamDataOut = mem[RamAddress];

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    checks++; if (RamEnable !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", RamEnable); end
    checks++; if (FAck !== 1'b0 || MAck !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b%b exp=00", FAck, MAck); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    checks++; if (RamReadWrite !== 1'b1) begin errors++; $display("FAIL reset_rw got=%b exp=1", RamReadWrite); end
    checks++; if (RamAddress !== 16'h0 || RamDataIn !== 32'h0) begin errors++; $display("FAIL reset_ram_bus addr=%h din=%h exp=0", RamAddress, RamDataIn); end
    checks++; if (FRData !== 32'h0 || MRData !== 32'h0) begin errors++; $display("FAIL reset_rdata f=%h m=%h exp=0", FRData, MRData); end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_f_read();
    preload(16'h0003, 32'hDEADBEEF);
    FReq = 1'b1; FAddr = 16'h0003;
    tick();
    checks++; if (RamEnable !== 1'b1 || RamReadWrite !== 1'b1) begin errors++; $display("FAIL fread_access en=%b rw=%b exp=1,1", RamEnable, RamReadWrite); end
    checks++; if (RamAddress !== 16'h0003) begin errors++; $display("FAIL fread_addr got=%h exp=0003", RamAddress); end
    checks++; if (FAck !== 1'b0 || Busy !== 1'b1) begin errors++; $display("FAIL fread_early ack=%b busy=%b exp=0,1", FAck, Busy); end
    tick();
    checks++; if (FAck !== 1'b1 || MAck !== 1'b0) begin errors++; $display("FAIL fread_ack f=%b m=%b exp=1,0", FAck, MAck); end
    checks++; if (FRData !== 32'hDEADBEEF) begin errors++; $display("FAIL fread_data got=%h exp=deadbeef", FRData); end
    checks++; if (RamEnable !== 1'b0) begin errors++; $display("FAIL fread_ack_en got=%b exp=0", RamEnable); end
    FReq = 1'b0;
    tick();
    checks++; if (FAck !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL fread_done ack=%b busy=%b exp=0,0", FAck, Busy); end
    checks++; if (FRData !== 32'hDEADBEEF) begin errors++; $display("FAIL fread_hold got=%h exp=deadbeef", FRData); end
  endtask

  task automatic test_store_load();
    MReq = 1'b1; MWrite = 1'b1; MAddr = 16'h0010; MWData = 32'h12345678;
    tick();
    checks++; if (RamEnable !== 1'b1 || RamReadWrite !== 1'b0) begin errors++; $display("FAIL store_access en=%b rw=%b exp=1,0", RamEnable, RamReadWrite); end
    checks++; if (RamDataIn !== 32'h12345678 || RamAddress !== 16'h0010) begin errors++; $display("FAIL store_bus din=%h addr=%h exp=12345678,0010", RamDataIn, RamAddress); end
    tick();
    checks++; if (MAck !== 1'b1 || FAck !== 1'b0) begin errors++; $display("FAIL store_ack m=%b f=%b exp=1,0", MAck, FAck); end
    checks++; if (MRData !== 32'h0) begin errors++; $display("FAIL store_mrdata got=%h exp=0", MRData); end
    MReq = 1'b0; MWrite = 1'b0; MWData = 32'hFFFF_FFFF;
    tick();
    checks++; if (mem[16'h0010] !== 32'h12345678) begin errors++; $display("FAIL store_mem got=%h exp=12345678", mem[16'h0010]); end
    MReq = 1'b1;
    tick();
    checks++; if (RamReadWrite !== 1'b1) begin errors++; $display("FAIL load_rw got=%b exp=1", RamReadWrite); end
    tick();
    checks++; if (MAck !== 1'b1 || MRData !== 32'h12345678) begin errors++; $display("FAIL load_data ack=%b got=%h exp=1,12345678", MAck, MRData); end
    MReq = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    int f_t, m_t, gap;
    preload(16'h0020, 32'hAAAA0001);
    preload(16'h0021, 32'hBBBB0002);
    for (int pair = 0; pair < 2; pair++) begin
      f_t = -1; m_t = -1;
      FReq = 1'b1; FAddr = 16'h0020;
      MReq = 1'b1; MWrite = 1'b0; MAddr = 16'h0021;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (c == 0) begin
          checks++; if (RamAddress !== FirstAddr) begin errors++; $display("FAIL prio_first_addr pair=%0d got=%h exp=%h", pair, RamAddress, FirstAddr); end
        end
        if (FAck && MAck) begin
          checks++; errors++; $display("FAIL prio_dual_ack pair=%0d cycle=%0d got=11 exp=one-hot", pair, c);
        end
        if (FAck && f_t < 0) begin
          f_t = c; FReq = 1'b0;
          checks++; if (FRData !== 32'hAAAA0001) begin errors++; $display("FAIL prio_fdata got=%h exp=aaaa0001", FRData); end
        end
        if (MAck && m_t < 0) begin
          m_t = c; MReq = 1'b0;
          checks++; if (MRData !== 32'hBBBB0002) begin errors++; $display("FAIL prio_mdata got=%h exp=bbbb0002", MRData); end
        end
      end
      FReq = 1'b0; MReq = 1'b0;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
      gap = m_t - f_t;
`else
      gap = f_t - m_t;
`endif
      checks++; if (f_t < 0 || m_t < 0) begin errors++; $display("FAIL prio_timeout pair=%0d f_t=%0d m_t=%0d exp=both acked", pair, f_t, m_t); end
      checks++; if (gap !== 3) begin errors++; $display("FAIL prio_order pair=%0d gap=%0d exp=3", pair, gap); end
      tick();
    end
  endtask

  task automatic test_late_drop();
    int start, acks;
    acks = 0;
    start = en_count;
    FReq = 1'b1; FAddr = 16'h0003;
    tick();
    tick();
    if (FAck) acks++;
    tick();
    FReq = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (FAck) acks++;
      checks++; if (RamEnable !== 1'b0) begin errors++; $display("FAIL late_drop_en cycle=%0d got=%b exp=0", c, RamEnable); end
    end
    checks++; if (en_count - start !== 1) begin errors++; $display("FAIL late_drop_accesses got=%0d exp=1", en_count - start); end
    checks++; if (acks !== 1) begin errors++; $display("FAIL late_drop_acks got=%0d exp=1", acks); end
  endtask

  task automatic test_reset_abort();
    FReq = 1'b1; FAddr = 16'h0003;
    tick();
    checks++; if (RamEnable !== 1'b1) begin errors++; $display("FAIL abort_pre_en got=%b exp=1", RamEnable); end
    Reset = 1'b1;
    tick();
    checks++; if (RamEnable !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL abort_state en=%b busy=%b exp=0,0", RamEnable, Busy); end
    checks++; if (FAck !== 1'b0 || FRData !== 32'h0) begin errors++; $display("FAIL abort_ack ack=%b data=%h exp=0,0", FAck, FRData); end
    Reset = 1'b0; FReq = 1'b0;
    tick();
    checks++; if (FAck !== 1'b0) begin errors++; $display("FAIL abort_no_ack got=%b exp=0", FAck); end
    FReq = 1'b1;
    tick();
    tick();
    checks++; if (FAck !== 1'b1 || FRData !== 32'hDEADBEEF) begin errors++; $display("FAIL abort_retry ack=%b data=%h exp=1,deadbeef", FAck, FRData); end
    FReq = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    int f_acks, m_acks;
    f_acks = 0; m_acks = 0;
    FReq = 1'b1; FAddr = 16'h0020;
    MReq = 1'b1; MWrite = 1'b0; MAddr = 16'h0021;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (FAck) f_acks++;
      if (MAck) m_acks++;
    end
    FReq = 1'b0; MReq = 1'b0;
    tick();
    tick();
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    checks++; if (f_acks !== 5 || m_acks !== 5) begin errors++; $display("FAIL rr_share f=%0d m=%0d exp=5,5", f_acks, m_acks); end
`else
    checks++; if (f_acks !== 0) begin errors++; $display("FAIL starve_f got=%0d exp=0", f_acks); end
    checks++; if (m_acks !== 10) begin errors++; $display("FAIL starve_m got=%0d exp=10", m_acks); end
`endif
  endtask

  initial begin
    Reset = 1'b1; FReq = 1'b0; FAddr = '0;
    MReq = 1'b0; MWrite = 1'b0; MAddr = '0; MWData = '0;
    test_reset();
    test_f_read();
    test_store_load();
    test_priority();
    test_late_drop();
    test_reset_abort();
    test_starvation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
